// File: rtl/neo_port_master.sv
// Cartridge port bus initiator: turns host commands into timed 68K-style word/byte cycles.
// Optional build macro NEO_PORT_MASTER_VERIFY_EN adds an automatic readback after every write.
`timescale 1ns/1ps
module neo_port_master #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2
) (
  input  logic        CLK_48M,
  input  logic        nRESET,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_WE,
  input  logic [1:0]  CMD_BE,
  input  logic [18:0] CMD_ADDR,
  input  logic [15:0] CMD_WDATA,
  output logic        RSP_VALID,
  output logic [15:0] RSP_DATA,
  output logic        RSP_ERR,
  output logic [18:0] M68K_ADDR,
  output logic [15:0] M68K_DOUT,
  output logic        M68K_DOE,
  input  logic [15:0] M68K_DIN,
  output logic        nPORTOEL,
  output logic        nPORTOEU,
  output logic        nPORTWEL,
  output logic        nPORTWEU
);

  localparam int STB    = (STROBE_CYC < 1) ? 1 : STROBE_CYC;
  localparam int MAX_SH = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int MAXP   = (STB > MAX_SH) ? STB : MAX_SH;
  localparam int CW     = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] SETUP_LAST = CW'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
  localparam logic [CW-1:0] STB_LAST   = CW'(STB - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            lat_we;
  logic [1:0]      lat_be;
  logic            rb;        // set while running the verify readback cycle
  logic [15:0]     rd_data;
  logic [1:0]      oe_n;      // [1] upper lane, [0] lower lane
  logic [1:0]      we_n;
  logic            cur_we;
  logic            bus_end;
  logic [15:0]     lane_mask;

  assign cur_we    = lat_we & ~rb;
  assign lane_mask = {{8{lat_be[1]}}, {8{lat_be[0]}}};
  // Last clock of the current bus cycle: end of HOLD, or end of STROBE when there is no HOLD.
  assign bus_end   = (cnt == '0) && ((state == HOLD) || (state == STROBE && HOLD_CYC == 0));

  assign nPORTOEU = oe_n[1];
  assign nPORTOEL = oe_n[0];
  assign nPORTWEU = we_n[1];
  assign nPORTWEL = we_n[0];

  // NOTE: every register here, including the datapath, is reset so that a reset mid-cycle
  // releases the bus immediately; all state uses non-blocking assignments.
  always_ff @(posedge CLK_48M or negedge nRESET) begin
    if (!nRESET) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_be    <= 2'b00;
      rb        <= 1'b0;
      rd_data   <= '0;
      oe_n      <= 2'b11;
      we_n      <= 2'b11;
      CMD_READY <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= '0;
      RSP_ERR   <= 1'b0;
      M68K_ADDR <= '0;
      M68K_DOUT <= '0;
      M68K_DOE  <= 1'b0;
    end else begin
      RSP_VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (CMD_READY && CMD_VALID) begin
            CMD_READY <= 1'b0;
            lat_we    <= CMD_WE;
            lat_be    <= CMD_BE;
            rb        <= 1'b0;
            M68K_ADDR <= CMD_ADDR;
            M68K_DOUT <= CMD_WDATA;
            M68K_DOE  <= CMD_WE && (CMD_BE != 2'b00);
            if (SETUP_CYC > 0) begin
              state <= SETUP;
              cnt   <= SETUP_LAST;
            end else begin
              state <= STROBE;
              cnt   <= STB_LAST;
              oe_n  <= CMD_WE ? 2'b11 : ~CMD_BE;
              we_n  <= CMD_WE ? ~CMD_BE : 2'b11;
            end
          end else begin
            CMD_READY <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state <= STROBE;
            cnt   <= STB_LAST;
            oe_n  <= cur_we ? 2'b11 : ~lat_be;
            we_n  <= cur_we ? ~lat_be : 2'b11;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            oe_n <= 2'b11;
            we_n <= 2'b11;
            if (!cur_we) rd_data <= M68K_DIN;
            if (HOLD_CYC > 0) begin
              state <= HOLD;
              cnt   <= HOLD_LAST;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        HOLD: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        DONE: begin
          state     <= IDLE;
          RSP_VALID <= 1'b1;
          CMD_READY <= 1'b1;
`ifdef NEO_PORT_MASTER_VERIFY_EN
          RSP_DATA  <= rd_data & lane_mask;
          RSP_ERR   <= lat_we && (((rd_data ^ M68K_DOUT) & lane_mask) != '0);
`else
          RSP_DATA  <= lat_we ? '0 : (rd_data & lane_mask);
          RSP_ERR   <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase

      // Overrides the phase logic above on the final clock of a bus cycle.
      if (bus_end) begin
        M68K_DOE <= 1'b0;
`ifdef NEO_PORT_MASTER_VERIFY_EN
        if (cur_we) begin
          rb <= 1'b1;
          if (SETUP_CYC > 0) begin
            state <= SETUP;
            cnt   <= SETUP_LAST;
          end else begin
            state <= STROBE;
            cnt   <= STB_LAST;
            oe_n  <= ~lat_be;
          end
        end else begin
          state <= DONE;
        end
`else
        state <= DONE;
`endif
      end
    end
  end

endmodule
